// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter.
// Shares the single register-file write port between the pipeline writeback
// stage and the multiply/divide unit (MDU). MDU results are held in a small
// in-order buffer and drained into free write-port cycles. An age counter
// forces the buffer head through after AGE_MAX denied cycles, stalling
// writeback for that one cycle.
//
// Ports:
//   clk, reset (async, active-low)
//   pipe_regwrite/pipe_writereg/pipe_result : writeback stage write request
//   mdu_valid/mdu_ready/mdu_writereg/mdu_result : MDU result handshake
//   stall_wb : writeback must re-present its write next cycle
//   rf_we/rf_wa/rf_wd : register file write port
//   chk_reg/chk_hit : hazard lookup against buffered writes
module regfile_wb_arbiter #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned AGE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_regwrite,
  input  logic [4:0]  pipe_writereg,
  input  logic [31:0] pipe_result,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_writereg,
  input  logic [31:0] mdu_result,
  output logic        stall_wb,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  input  logic [4:0]  chk_reg,
  output logic        chk_hit
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned GW = $clog2(AGE_MAX + 1);

  logic [4:0]    reg_mem  [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [GW-1:0] age;

  logic pipe_wr;
  logic head_valid;
  logic force_pop;
  logic pop;
  logic push;
  logic store;
  logic hit_any;

  // Grant, handshake and hazard lookup; every output is held low in reset.
  always_comb begin
    pipe_wr    = pipe_regwrite && (pipe_writereg != 5'd0);
    head_valid = (count != '0);
    force_pop  = head_valid && (age == GW'(AGE_MAX));
    pop        = reset && head_valid && (!pipe_wr || force_pop);
    // A same-cycle pop frees a slot for the incoming result.
    mdu_ready  = reset && ((count < CW'(DEPTH)) || pop);
    push       = mdu_valid && mdu_ready;
    // Results for register 0 are acknowledged but never stored.
    store      = push && (mdu_writereg != 5'd0);

    rf_we    = 1'b0;
    rf_wa    = 5'd0;
    rf_wd    = 32'd0;
    stall_wb = 1'b0;
    if (pop) begin
      rf_we    = 1'b1;
      rf_wa    = reg_mem[rd_ptr];
      rf_wd    = data_mem[rd_ptr];
      stall_wb = pipe_wr;
    end else if (reset && pipe_wr) begin
      rf_we = 1'b1;
      rf_wa = pipe_writereg;
      rf_wd = pipe_result;
    end

    // Only occupied slots, counted from the head, take part in the lookup.
    hit_any = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if ((CW'(i) < count) && (reg_mem[rd_ptr + AW'(i)] == chk_reg)) begin
        hit_any = 1'b1;
      end
    end
    chk_hit = reset && (chk_reg != 5'd0) && hit_any;
  end

  // Pointers, occupancy and head age.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      age    <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (store) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      case ({store, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Age restarts for each new head and saturates at the force threshold.
      if (pop || !head_valid) begin
        age <= '0;
      end else if (age != GW'(AGE_MAX)) begin
        age <= age + GW'(1);
      end
    end
  end

  // Buffer payload storage; contents are meaningful only below count.
  always_ff @(posedge clk) begin
    if (store) begin
      reg_mem[wr_ptr]  <= mdu_writereg;
      data_mem[wr_ptr] <= mdu_result;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed vector table, reset sequences
// and randomized traffic checked against a queue-based reference model.
module tb_regfile_wb_arbiter;

  localparam int unsigned DEPTH   = 2;
  localparam int unsigned AGE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_regwrite;
  logic [4:0]  pipe_writereg;
  logic [31:0] pipe_result;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_writereg;
  logic [31:0] mdu_result;
  logic        stall_wb;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [4:0]  chk_reg;
  logic        chk_hit;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .AGE_MAX(AGE_MAX)) dut (
    .clk(clk), .reset(reset),
    .pipe_regwrite(pipe_regwrite), .pipe_writereg(pipe_writereg), .pipe_result(pipe_result),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_writereg(mdu_writereg), .mdu_result(mdu_result),
    .stall_wb(stall_wb), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .chk_reg(chk_reg), .chk_hit(chk_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        prw;
    logic [4:0]  pwr;
    logic [31:0] pres;
    logic        mv;
    logic [4:0]  mwr;
    logic [31:0] mres;
    logic [4:0]  chk;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        st;
    logic        rdy;
    logic        hit;
  } vec_t;

  localparam int NVEC = 20;
  vec_t tbl [NVEC];

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: pending MDU writes in acceptance order plus head wait time.
  logic [36:0] mq [$];
  int          m_age;
  logic        e_we, e_st, e_rdy, e_hit, e_grant_head;
  logic [4:0]  e_wa;
  logic [31:0] e_wd;

  function automatic vec_t mk(logic prw, logic [4:0] pwr, logic [31:0] pres,
                              logic mv, logic [4:0] mwr, logic [31:0] mres, logic [4:0] chk,
                              logic we, logic [4:0] wa, logic [31:0] wd,
                              logic st, logic rdy, logic hit);
    vec_t v;
    v.prw = prw; v.pwr = pwr; v.pres = pres; v.mv = mv; v.mwr = mwr; v.mres = mres;
    v.chk = chk; v.we = we; v.wa = wa; v.wd = wd; v.st = st; v.rdy = rdy; v.hit = hit;
    return v;
  endfunction

  function automatic void model_eval();
    logic        pw;
    logic [36:0] head;
    pw   = pipe_regwrite && (pipe_writereg != 5'd0);
    head = (mq.size() > 0) ? mq[0] : 37'd0;
    e_grant_head = (mq.size() > 0) && (!pw || (m_age == int'(AGE_MAX)));
    e_we  = e_grant_head || pw;
    e_st  = e_grant_head && pw;
    e_rdy = (mq.size() < int'(DEPTH)) || e_grant_head;
    if (e_grant_head) begin
      e_wa = head[36:32];
      e_wd = head[31:0];
    end else if (pw) begin
      e_wa = pipe_writereg;
      e_wd = pipe_result;
    end else begin
      e_wa = 5'd0;
      e_wd = 32'd0;
    end
    e_hit = 1'b0;
    if (chk_reg != 5'd0) begin
      foreach (mq[k]) begin
        head = mq[k];
        if (head[36:32] == chk_reg) e_hit = 1'b1;
      end
    end
  endfunction

  // Called right after a clock edge, while the pre-edge inputs are still applied.
  function automatic void model_edge();
    model_eval();
    if (e_grant_head) begin
      void'(mq.pop_front());
      m_age = 0;
    end else if (mq.size() == 0) begin
      m_age = 0;
    end else if (m_age < int'(AGE_MAX)) begin
      m_age++;
    end
    if (mdu_valid && e_rdy && (mdu_writereg != 5'd0)) mq.push_back({mdu_writereg, mdu_result});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_all(input string tag, input logic we, input logic [4:0] wa,
                           input logic [31:0] wd, input logic st, input logic rdy, input logic hit);
    check({tag, " rf_we"}, 32'(rf_we), 32'(we));
    check({tag, " rf_wa"}, 32'(rf_wa), 32'(wa));
    check({tag, " rf_wd"}, rf_wd, wd);
    check({tag, " stall_wb"}, 32'(stall_wb), 32'(st));
    check({tag, " mdu_ready"}, 32'(mdu_ready), 32'(rdy));
    check({tag, " chk_hit"}, 32'(chk_hit), 32'(hit));
  endtask

  task automatic drive(input vec_t v);
    pipe_regwrite = v.prw; pipe_writereg = v.pwr; pipe_result = v.pres;
    mdu_valid = v.mv; mdu_writereg = v.mwr; mdu_result = v.mres; chk_reg = v.chk;
  endtask

  task automatic drive_idle(input logic [4:0] chk);
    pipe_regwrite = 1'b0; pipe_writereg = 5'd0; pipe_result = 32'd0;
    mdu_valid = 1'b0; mdu_writereg = 5'd0; mdu_result = 32'd0; chk_reg = chk;
  endtask

  initial begin
    logic prev_stall;

    //           prw pwr    pres          mv mwr    mres          chk    we wa     wd            st rdy hit
    tbl[0]  = mk(1, 5'd5,  32'h0000_1234, 0, 5'd0,  32'h0,        5'd0,  1, 5'd5,  32'h0000_1234, 0, 1, 0);
    tbl[1]  = mk(0, 5'd0,  32'h0,         1, 5'd8,  32'hDEAD_BEEF, 5'd8, 0, 5'd0,  32'h0,         0, 1, 0);
    tbl[2]  = mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,        5'd8,  1, 5'd8,  32'hDEAD_BEEF, 0, 1, 1);
    tbl[3]  = mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,        5'd8,  0, 5'd0,  32'h0,         0, 1, 0);
    tbl[4]  = mk(1, 5'd0,  32'h55,        1, 5'd0,  32'h99,       5'd0,  0, 5'd0,  32'h0,         0, 1, 0);
    tbl[5]  = mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,        5'd0,  0, 5'd0,  32'h0,         0, 1, 0);
    tbl[6]  = mk(1, 5'd10, 32'hA0,        1, 5'd11, 32'hB0,       5'd11, 1, 5'd10, 32'hA0,        0, 1, 0);
    tbl[7]  = mk(1, 5'd12, 32'hC0,        0, 5'd0,  32'h0,        5'd11, 1, 5'd12, 32'hC0,        0, 1, 1);
    tbl[8]  = mk(1, 5'd13, 32'hD0,        0, 5'd0,  32'h0,        5'd11, 1, 5'd13, 32'hD0,        0, 1, 1);
    tbl[9]  = mk(1, 5'd14, 32'hE0,        0, 5'd0,  32'h0,        5'd11, 1, 5'd14, 32'hE0,        0, 1, 1);
    tbl[10] = mk(1, 5'd15, 32'hF0,        0, 5'd0,  32'h0,        5'd11, 1, 5'd15, 32'hF0,        0, 1, 1);
    tbl[11] = mk(1, 5'd16, 32'h100,       0, 5'd0,  32'h0,        5'd11, 1, 5'd11, 32'hB0,        1, 1, 1);
    tbl[12] = mk(1, 5'd16, 32'h100,       0, 5'd0,  32'h0,        5'd11, 1, 5'd16, 32'h100,       0, 1, 0);
    tbl[13] = mk(1, 5'd20, 32'h200,       1, 5'd3,  32'h33,       5'd3,  1, 5'd20, 32'h200,       0, 1, 0);
    tbl[14] = mk(1, 5'd21, 32'h210,       1, 5'd4,  32'h44,       5'd3,  1, 5'd21, 32'h210,       0, 1, 1);
    tbl[15] = mk(1, 5'd22, 32'h220,       1, 5'd6,  32'h66,       5'd4,  1, 5'd22, 32'h220,       0, 0, 1);
    tbl[16] = mk(1, 5'd23, 32'h230,       0, 5'd0,  32'h0,        5'd5,  1, 5'd23, 32'h230,       0, 0, 0);
    tbl[17] = mk(1, 5'd24, 32'h240,       0, 5'd0,  32'h0,        5'd3,  1, 5'd24, 32'h240,       0, 0, 1);
    tbl[18] = mk(1, 5'd25, 32'h250,       1, 5'd6,  32'h66,       5'd3,  1, 5'd3,  32'h33,        1, 1, 1);
    tbl[19] = mk(1, 5'd25, 32'h250,       0, 5'd0,  32'h0,        5'd6,  1, 5'd25, 32'h250,       0, 0, 1);

    m_age = 0;
    reset = 1'b0;
    drive(mk(1, 5'd5, 32'h77, 1, 5'd9, 32'h88, 5'd9, 0, 5'd0, 32'h0, 0, 0, 0));
    #1;
    check_all("in_reset", 0, 5'd0, 32'h0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i]);
      #4;
      check_all($sformatf("vec%0d", i), tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].st, tbl[i].rdy, tbl[i].hit);
      @(posedge clk);
      model_edge();
      #1;
    end

    // Reset with two entries (regs 4 and 6) buffered.
    drive(mk(1, 5'd26, 32'h260, 1, 5'd7, 32'h70, 5'd4, 0, 5'd0, 32'h0, 0, 0, 0));
    reset = 1'b0;
    #4;
    check_all("mid_reset", 0, 5'd0, 32'h0, 0, 0, 0);
    mq.delete();
    m_age = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive_idle(5'd4);
    #4;
    check_all("post_reset", 0, 5'd0, 32'h0, 0, 1, 0);
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 3; i++) begin
      drive_idle(5'd6);
      #4;
      check_all($sformatf("no_stale%0d", i), 0, 5'd0, 32'h0, 0, 1, 0);
      @(posedge clk);
      model_edge();
      #1;
    end

    // Random traffic; a stalled writeback re-presents the same write.
    prev_stall = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!prev_stall) begin
        pipe_regwrite = ($urandom_range(0, 9) < 7);
        pipe_writereg = 5'($urandom_range(0, 7));
        pipe_result   = $urandom;
      end
      mdu_valid    = ($urandom_range(0, 9) < 4);
      mdu_writereg = 5'($urandom_range(0, 7));
      mdu_result   = $urandom;
      chk_reg      = 5'($urandom_range(0, 7));
      model_eval();
      #4;
      check_all($sformatf("rnd%0d", c), e_we, e_wa, e_wd, e_st, e_rdy, e_hit);
      prev_stall = e_st;
      @(posedge clk);
      model_edge();
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
